// File: rtl/scroll_engine.sv
// scroll_engine: moves text-buffer lines up/down inside [top, bottom] and
// blanks the vacated lines, one RAM cell per cycle.
// Optional feature macro: SCROLL_ENGINE_FILL_ATTR_EN (blank cells take the
// attribute latched from fill_attr at accept instead of BLANK's attribute).
module scroll_engine #(
  parameter int unsigned       COLUMNS = 80,
  parameter int unsigned       LINES   = 24,
  parameter int unsigned       ADDR_W  = 12,
  parameter int unsigned       CHAR_W  = 16,
  parameter logic [CHAR_W-1:0] BLANK   = 16'h0720
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_dir,
  input  logic [7:0]        req_step,
  input  logic [7:0]        req_top,
  input  logic [7:0]        req_bottom,
  input  logic [7:0]        fill_attr,
  output logic              busy,
  output logic              done,
  output logic              lost,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [CHAR_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [CHAR_W-1:0] ram_wdata
);

  localparam int unsigned       COL_W    = $clog2(COLUMNS);
  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(COLUMNS);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLUMNS - 1);
  localparam logic [8:0]        LINES_9  = 9'(LINES);

  typedef enum logic [2:0] {IDLE, COPY, DRAIN, CLEAR, FINISH} state_t;

  // Start address of a line; constant multiply only, reduces to shifts/adds.
  function automatic logic [ADDR_W-1:0] line_base(input logic [7:0] line);
    return ADDR_W'(32'(line) * COLUMNS);
  endfunction

  state_t             state_q, state_d;
  logic               dir_q, dir_d;
  logic [7:0]         s_q, s_d;
  logic [ADDR_W-1:0]  src_base_q, src_base_d;
  logic [ADDR_W-1:0]  dst_base_q, dst_base_d;
  logic [ADDR_W-1:0]  clr_base_q, clr_base_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [7:0]         lines_left_q, lines_left_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               lost_q, lost_d;
  logic               we_q, we_d;
  logic               cp_sel_q, cp_sel_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [CHAR_W-1:0]  wdata_q, wdata_d;

  logic [8:0]         req_height;
  logic               req_ok;
  logic [7:0]         req_s;
  logic [7:0]         req_copy_lines;
  logic               accept;
  logic [CHAR_W-1:0]  blank_val;

  assign accept = (state_q == IDLE) && req_valid && !busy_q;

  // Request decode: validity, clamped step and number of lines to copy
  always_comb begin
    req_height     = 9'(req_bottom) - 9'(req_top) + 9'd1;
    req_ok         = (req_top <= req_bottom) && (9'(req_bottom) < LINES_9);
    req_s          = 8'd0;
    if (req_ok) begin
      req_s = (9'(req_step) < req_height) ? req_step : req_height[7:0];
    end
    req_copy_lines = req_ok ? 8'(req_height - 9'(req_s)) : 8'd0;
  end

`ifdef SCROLL_ENGINE_FILL_ATTR_EN
  logic [7:0] attr_q, attr_d;

  // Capture the fill attribute together with the request
  always_comb begin
    attr_d = attr_q;
    if (accept) attr_d = fill_attr;
  end

  // Fill attribute register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) attr_q <= 8'd0;
    else     attr_q <= attr_d;
  end

  assign blank_val = CHAR_W'({attr_q, BLANK[7:0]});
`else
  logic unused_fill_attr;
  assign unused_fill_attr = ^fill_attr;
  assign blank_val        = BLANK;
`endif

  // Next-state and output computation
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    s_d          = s_q;
    src_base_d   = src_base_q;
    dst_base_d   = dst_base_q;
    clr_base_d   = clr_base_q;
    col_d        = col_q;
    lines_left_d = lines_left_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    lost_d       = lost_q | (req_valid & busy_q);
    we_d         = 1'b0;
    cp_sel_d     = 1'b0;
    raddr_d      = raddr_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          busy_d       = 1'b1;
          dir_d        = req_dir;
          s_d          = req_s;
          col_d        = '0;
          lines_left_d = req_copy_lines;
          if (req_dir) begin
            src_base_d = line_base(req_bottom - req_s);
            dst_base_d = line_base(req_bottom);
            clr_base_d = line_base(req_top);
          end else begin
            src_base_d = line_base(req_top + req_s);
            dst_base_d = line_base(req_top);
            clr_base_d = line_base(req_bottom - req_s + 8'd1);
          end
          raddr_d = src_base_d;
          state_d = (req_copy_lines != 8'd0) ? COPY : DRAIN;
        end
      end

      COPY: begin
        // Read issued this cycle is written next cycle
        waddr_d  = dst_base_q + ADDR_W'(col_q);
        we_d     = 1'b1;
        cp_sel_d = 1'b1;
        if (col_q == COL_LAST) begin
          col_d        = '0;
          lines_left_d = lines_left_q - 8'd1;
          if (lines_left_q == 8'd1) begin
            state_d = DRAIN;
          end else begin
            if (dir_q) begin
              src_base_d = src_base_q - COL_STEP;
              dst_base_d = dst_base_q - COL_STEP;
            end else begin
              src_base_d = src_base_q + COL_STEP;
              dst_base_d = dst_base_q + COL_STEP;
            end
            raddr_d = src_base_d;
          end
        end else begin
          col_d   = col_q + COL_W'(1);
          raddr_d = raddr_q + ADDR_W'(1);
        end
      end

      DRAIN: begin
        if (s_q != 8'd0) begin
          state_d      = CLEAR;
          we_d         = 1'b1;
          waddr_d      = clr_base_q;
          wdata_d      = blank_val;
          col_d        = '0;
          lines_left_d = s_q;
        end else begin
          state_d = FINISH;
        end
      end

      CLEAR: begin
        // Vacated lines are contiguous in memory in both directions
        if ((col_q == COL_LAST) && (lines_left_q == 8'd1)) begin
          state_d = FINISH;
        end else begin
          we_d    = 1'b1;
          waddr_d = waddr_q + ADDR_W'(1);
          if (col_q == COL_LAST) begin
            col_d        = '0;
            lines_left_d = lines_left_q - 8'd1;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      s_q          <= 8'd0;
      src_base_q   <= '0;
      dst_base_q   <= '0;
      clr_base_q   <= '0;
      col_q        <= '0;
      lines_left_q <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lost_q       <= 1'b0;
      we_q         <= 1'b0;
      cp_sel_q     <= 1'b0;
      raddr_q      <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      s_q          <= s_d;
      src_base_q   <= src_base_d;
      dst_base_q   <= dst_base_d;
      clr_base_q   <= clr_base_d;
      col_q        <= col_d;
      lines_left_q <= lines_left_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      lost_q       <= lost_d;
      we_q         <= we_d;
      cp_sel_q     <= cp_sel_d;
      raddr_q      <= raddr_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign lost      = lost_q;
  assign ram_raddr = raddr_q;
  assign ram_we    = we_q;
  assign ram_waddr = waddr_q;
  // Copy writes forward the read data arriving this cycle; clears use the held blank.
  assign ram_wdata = cp_sel_q ? ram_rdata : wdata_q;

endmodule

// File: tb/tb_scroll_engine.sv
// tb_scroll_engine: directed and randomized scroll requests checked against a
// line-level screen model; the bench owns the text RAM.
module tb_scroll_engine;

  localparam int COLS   = 80;
  localparam int NLINES = 24;
  localparam int MEMSZ  = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_dir;
  logic [7:0]  req_step;
  logic [7:0]  req_top;
  logic [7:0]  req_bottom;
  logic [7:0]  fill_attr;
  logic        busy;
  logic        done;
  logic        lost;
  logic [11:0] ram_raddr;
  logic [15:0] ram_rdata;
  logic        ram_we;
  logic [11:0] ram_waddr;
  logic [15:0] ram_wdata;

  logic [15:0] mem     [0:MEMSZ-1];
  logic [15:0] old_mem [0:MEMSZ-1];
  logic [15:0] exp_mem [0:MEMSZ-1];

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  scroll_engine dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_dir    (req_dir),
    .req_step   (req_step),
    .req_top    (req_top),
    .req_bottom (req_bottom),
    .fill_attr  (fill_attr),
    .busy       (busy),
    .done       (done),
    .lost       (lost),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read text RAM; read returns the pre-write contents
  always @(posedge clk) begin
    ram_rdata <= mem[ram_raddr];
    if (ram_we) begin
      mem[ram_waddr] = ram_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  // Count done pulses
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Build the expected screen from line-level scroll rules, then run the request
  task automatic do_op(input string tag, input logic dir, input logic [7:0] step,
                       input logic [7:0] top, input logic [7:0] bot,
                       input logic [7:0] attr, input bit overlap);
    int t, b, h, s, src, exp_wr, exp_cyc, cyc, w0, d0, mism;
    bit valid;
    logic [15:0] blank;
    fill_attr = attr;
`ifdef SCROLL_ENGINE_FILL_ATTR_EN
    blank = {fill_attr, 8'h20};
`else
    blank = 16'h0720;
`endif
    t = int'(top);
    b = int'(bot);
    valid = (t <= b) && (b < NLINES);
    h = b - t + 1;
    s = 0;
    if (valid) s = (int'(step) < h) ? int'(step) : h;
    for (int a = 0; a < MEMSZ; a++) begin
      old_mem[a] = mem[a];
      exp_mem[a] = mem[a];
    end
    if (valid) begin
      for (int l = t; l <= b; l++) begin
        src = dir ? l - s : l + s;
        for (int c = 0; c < COLS; c++) begin
          if (src >= t && src <= b) exp_mem[l*COLS + c] = old_mem[src*COLS + c];
          else                      exp_mem[l*COLS + c] = blank;
        end
      end
    end
    exp_wr  = valid ? h * COLS : 0;
    exp_cyc = exp_wr + 2;

    w0 = wr_cnt;
    d0 = done_cnt;
    @(negedge clk);
    req_dir = dir; req_step = step; req_top = top; req_bottom = bot; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 5000) begin
      cyc++;
      if (overlap && cyc == 1) begin
        req_valid = 1'b1; req_dir = ~dir; req_top = 8'd0; req_bottom = 8'd23; req_step = 8'd3;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_done_pulse"}, 32'(done), 32'd1);
    @(negedge clk);
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(exp_wr));
    mism = 0;
    for (int a = 0; a < MEMSZ; a++) if (mem[a] !== exp_mem[a]) mism++;
    check({tag, "_mem_mismatches"}, 32'(mism), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_dir = 1'b0; req_step = 8'd0; req_top = 8'd0; req_bottom = 8'd0;
    fill_attr = 8'd0;
    for (int a = 0; a < MEMSZ; a++) mem[a] = 16'($urandom);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_lost", 32'(lost), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_raddr", 32'(ram_raddr), 32'd0);
    check("rst_waddr", 32'(ram_waddr), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("up_full",     1'b0, 8'd1,  8'd0,  8'd23, 8'h00, 1'b0);
    do_op("down_region", 1'b1, 8'd2,  8'd5,  8'd10, 8'h00, 1'b0);
    do_op("clamp",       1'b0, 8'd9,  8'd3,  8'd4,  8'h1F, 1'b0);
    do_op("invalid",     1'b0, 8'd1,  8'd12, 8'd4,  8'h00, 1'b0);
    do_op("off_screen",  1'b1, 8'd1,  8'd24, 8'd30, 8'h00, 1'b0);
    do_op("down_max",    1'b1, 8'd23, 8'd0,  8'd23, 8'h4E, 1'b0);
    do_op("up_last",     1'b0, 8'd1,  8'd23, 8'd23, 8'h00, 1'b0);
    check("lost_before_overlap", 32'(lost), 32'd0);
    do_op("overlap",     1'b1, 8'd2,  8'd5,  8'd10, 8'h00, 1'b1);
    check("lost_after_overlap", 32'(lost), 32'd1);

    // Reset about 100 cycles into a full-screen copy
    @(negedge clk);
    req_dir = 1'b0; req_step = 8'd1; req_top = 8'd0; req_bottom = 8'd23; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (99) @(negedge clk);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_we", 32'(ram_we), 32'd0);
    check("rst_mid_lost", 32'(lost), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    do_op("after_rst", 1'b1, 8'd3, 8'd2, 8'd20, 8'h1F, 1'b0);

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 8'($urandom_range(1, 30)),
            8'($urandom_range(0, 25)), 8'($urandom_range(0, 25)), 8'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
